conv_lbx_ctrl: RTL

- Frame sequencer in front of the conv line buffer.
- Accepts a raw pixel stream with a start-of-frame marker and tracks column and row counters.
- Drives the line buffer's valid, data, end-of-line and stall inputs, and reports when a full KERNEL x KERNEL window is centred on a real pixel.
- At end of frame it injects zero-padding lines so the last rows drain out, then pulses frame_done_o. Sits between the pixel source and conv_lbx.

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_lbx_ctrl_cnt.sv | 43 ++++
 rtl/conv_lbx_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types for the conv line-buffer path: pixel format and the
// frame-sequencer state encoding.
package conv_pkg;
  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    FLUSH,
    DONE
  } lbx_ctrl_state_t;
endpackage

// File: rtl/conv_lbx_ctrl_cnt.sv
// Push-position counter for the line-buffer sequencer: column wraps at
// W-1 and advances the row; flags end-of-line and the last real frame line.
module conv_lbx_ctrl_cnt #(
  parameter int W        = 640,
  parameter int LAST_ROW = 479,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_eol,
  output logic             o_last
);
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_eol  = (r_col == COL_W'(W - 1));
  assign o_last = (r_row == ROW_W'(LAST_ROW));

  // Row keeps counting past the frame so the pad lines have their own rows.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (o_eol) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/conv_lbx_ctrl.sv
// Frame sequencer feeding conv_lbx: counts pixel positions, flags centred windows
// and pads HALF zero lines at frame end. Optional checking: CONV_LBX_CTRL_CHECK_EN.
module conv_lbx_ctrl
  import conv_pkg::*;
#(
  parameter int W      = 640,
  parameter int H      = 480,
  parameter int KERNEL = 3
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   s_vld_i,
  input  logic [PIXEL_W-1:0]     s_dat_i,
  input  logic                   s_sof_i,
  output logic                   s_rdy_o,
  input  logic                   stall_i,
  output logic                   lb_vld_o,
  output logic [PIXEL_W-1:0]     lb_dat_o,
  output logic                   lb_eol_o,
  output logic                   lb_stall_o,
  output logic                   win_vld_o,
  output logic [$clog2(H)-1:0]   win_row_o,
  output logic [$clog2(W)-1:0]   win_col_o,
  output logic                   frame_done_o,
  output logic                   err_o
);
  localparam int HALF   = (KERNEL - 1) / 2;
  localparam int COL_W  = $clog2(W);
  localparam int WIN_RW = $clog2(H);
  localparam int ROW_W  = $clog2(H + HALF + 1);

  localparam logic [ROW_W-1:0] ROW_HALF      = ROW_W'(HALF);
  localparam logic [ROW_W-1:0] ROW_PRIME_END = ROW_W'(HALF - 1);
  localparam logic [ROW_W-1:0] ROW_PAD_END   = ROW_W'(H + HALF - 1);

  lbx_ctrl_state_t r_state, w_state_nxt;

  logic             w_acc, w_push, w_win, w_clr, w_eol, w_last;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  pixel_t           w_dat;

  logic             r_lb_vld, r_lb_eol, r_win_vld;
  pixel_t           r_lb_dat;
  logic [WIN_RW-1:0] r_win_row;
  logic [COL_W-1:0]  r_win_col;

  assign lb_stall_o   = stall_i;
  assign s_rdy_o      = !stall_i && (r_state inside {IDLE, PRIME, RUN});
  assign w_acc        = s_vld_i && s_rdy_o;
  assign frame_done_o = (r_state == DONE);
  assign w_win        = w_push && ((HALF == 0) || (r_state == RUN) || (r_state == FLUSH));

  conv_lbx_ctrl_cnt #(
    .W        (W),
    .LAST_ROW (H - 1),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .i_en   (w_push),
    .i_clr  (w_clr),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_eol  (w_eol),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // DONE never waits on stall so frame_done_o stays a single-cycle pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_clr       = 1'b0;
    w_dat       = s_dat_i;
    case (r_state)
      IDLE: begin
        if (w_acc && s_sof_i) begin
          w_push      = 1'b1;
          w_state_nxt = (HALF == 0) ? RUN : PRIME;
        end
      end
      PRIME: begin
        if (w_acc) begin
          w_push = 1'b1;
          if (w_eol && (w_row == ROW_PRIME_END)) w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_acc) begin
          w_push = 1'b1;
          if (w_eol && w_last) w_state_nxt = (HALF == 0) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        w_dat = '0;
        if (!stall_i) begin
          w_push = 1'b1;
          if (w_eol && (w_row == ROW_PAD_END)) w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_clr       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output stage: one register between push decision and the line buffer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_lb_vld  <= 1'b0;
      r_lb_dat  <= '0;
      r_lb_eol  <= 1'b0;
      r_win_vld <= 1'b0;
      r_win_row <= '0;
      r_win_col <= '0;
    end else begin
      r_lb_vld  <= w_push;
      r_lb_eol  <= w_push && w_eol;
      r_win_vld <= w_win;
      if (w_push) begin
        r_lb_dat  <= w_dat;
        r_win_row <= WIN_RW'(w_row - ROW_HALF);
        r_win_col <= w_col;
      end
    end
  end

  assign lb_vld_o  = r_lb_vld;
  assign lb_dat_o  = r_lb_dat;
  assign lb_eol_o  = r_lb_eol;
  assign win_vld_o = r_win_vld;
  assign win_row_o = r_win_row;
  assign win_col_o = r_win_col;

`ifdef CONV_LBX_CTRL_CHECK_EN
  logic r_err;
  logic w_sof_misplaced, w_origin_no_sof;

  assign w_sof_misplaced = w_acc && s_sof_i && (r_state != IDLE);
  assign w_origin_no_sof = w_push && (w_col == '0) && (w_row == '0) && !s_sof_i;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                                 r_err <= 1'b0;
    else if (w_sof_misplaced || w_origin_no_sof) r_err <= 1'b1;
  end

  always @(posedge clk) begin
    if (arst_n) begin
      assert (!$isunknown(s_vld_i));
      assert (!w_origin_no_sof);
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif
endmodule
